// File: rtl/u_ins_mem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory program-load controller.
package u_ins_mem_ctrl_pkg;

    localparam logic [31:0] P_TEXT_BASE = 32'h0040_0000;
    localparam int unsigned P_INS_BYTES = 4;
    localparam int unsigned P_BYTE_W    = 8;
    localparam int unsigned P_WORD_W    = P_INS_BYTES * P_BYTE_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } t_ins_ctrl_state;

endpackage

// File: rtl/u_ins_mem_ctrl_if.sv
// Loader, IF-stage and instruction-memory port bundle of the load controller.
interface u_ins_mem_ctrl_if;
    import u_ins_mem_ctrl_pkg::*;

    logic                i_u_ins_mem_ctrl_load_start;
    logic [15:0]         i_u_ins_mem_ctrl_word_cnt;
    logic                i_u_ins_mem_ctrl_abort;
    logic [P_BYTE_W-1:0] i_u_ins_mem_ctrl_byte;
    logic                i_u_ins_mem_ctrl_byte_valid;
    logic                o_u_ins_mem_ctrl_byte_ready;
    logic [31:0]         i_u_ins_mem_ctrl_pc;
    logic [31:0]         o_u_ins_mem_ctrl_ins_addr;
    logic [P_WORD_W-1:0] o_u_ins_mem_ctrl_wr_ins;
    logic                o_u_ins_mem_ctrl_wr_en;
    logic                o_u_ins_mem_ctrl_cpu_stall;
    logic                o_u_ins_mem_ctrl_busy;
    logic                o_u_ins_mem_ctrl_done;
    logic                o_u_ins_mem_ctrl_err;

    modport slave (
        input  i_u_ins_mem_ctrl_load_start, i_u_ins_mem_ctrl_word_cnt, i_u_ins_mem_ctrl_abort,
        input  i_u_ins_mem_ctrl_byte, i_u_ins_mem_ctrl_byte_valid, i_u_ins_mem_ctrl_pc,
        output o_u_ins_mem_ctrl_byte_ready, o_u_ins_mem_ctrl_ins_addr, o_u_ins_mem_ctrl_wr_ins,
        output o_u_ins_mem_ctrl_wr_en, o_u_ins_mem_ctrl_cpu_stall, o_u_ins_mem_ctrl_busy,
        output o_u_ins_mem_ctrl_done, o_u_ins_mem_ctrl_err
    );

    modport master (
        output i_u_ins_mem_ctrl_load_start, i_u_ins_mem_ctrl_word_cnt, i_u_ins_mem_ctrl_abort,
        output i_u_ins_mem_ctrl_byte, i_u_ins_mem_ctrl_byte_valid, i_u_ins_mem_ctrl_pc,
        input  o_u_ins_mem_ctrl_byte_ready, o_u_ins_mem_ctrl_ins_addr, o_u_ins_mem_ctrl_wr_ins,
        input  o_u_ins_mem_ctrl_wr_en, o_u_ins_mem_ctrl_cpu_stall, o_u_ins_mem_ctrl_busy,
        input  o_u_ins_mem_ctrl_done, o_u_ins_mem_ctrl_err
    );

endinterface

// File: rtl/u_byte_packer.sv
// Big-endian byte packer: holds the first three bytes, presents the full word with the 4th.
module u_byte_packer
    import u_ins_mem_ctrl_pkg::*;
(
    input  logic                i_sys_clock,
    input  logic                i_sys_reset,
    input  logic                clear_i,
    input  logic                push_i,
    input  logic [P_BYTE_W-1:0] byte_i,
    output logic                full_c,
    output logic [P_WORD_W-1:0] word_c
);

    localparam int unsigned CNT_W  = $clog2(P_INS_BYTES);
    localparam int unsigned HOLD_W = P_WORD_W - P_BYTE_W;

    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [HOLD_W-1:0] word_q, word_d;

    // The last byte is never stored; it is spliced in combinationally on the write cycle.
    assign full_c = push_i && (byte_cnt_q == CNT_W'(P_INS_BYTES - 1));
    assign word_c = {word_q, byte_i};

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        if (clear_i) begin
            byte_cnt_d = '0;
            word_d     = '0;
        end else if (push_i) begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
            word_d     = {word_q[HOLD_W-P_BYTE_W-1:0], byte_i};
        end
    end

    always_ff @(posedge i_sys_clock or posedge i_sys_reset) begin
        if (i_sys_reset) begin
            byte_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
        end
    end

endmodule

// File: rtl/u_ins_mem_ctrl.sv
// Instruction-memory port owner: PC fetch passthrough or sequential program load from a byte stream.
module u_ins_mem_ctrl
    import u_ins_mem_ctrl_pkg::*;
#(
    parameter logic [31:0] P_BASE_ADDR   = P_TEXT_BASE,
    parameter int unsigned P_DEPTH_WORDS = 256
) (
    input  logic             i_sys_clock,
    input  logic             i_sys_reset,
    u_ins_mem_ctrl_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(P_DEPTH_WORDS + 1);

    t_ins_ctrl_state     state_q, state_d;
    logic [IDX_W-1:0]    count_q, count_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                ready_q, ready_d;
    logic                wr_en_q, wr_en_d;
    logic [P_WORD_W-1:0] wr_ins_q, wr_ins_d;
    logic                stall_q, stall_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                pk_clear, pk_push, pk_full;
    logic [P_WORD_W-1:0] pk_word;
    logic                cnt_legal;

    assign cnt_legal = (bus.i_u_ins_mem_ctrl_word_cnt != 16'd0) &&
                       (32'(bus.i_u_ins_mem_ctrl_word_cnt) <= P_DEPTH_WORDS);

    // Abort takes priority over a byte arriving in the same cycle.
    assign pk_clear = (state_q != S_COLLECT);
    assign pk_push  = (state_q == S_COLLECT) && bus.i_u_ins_mem_ctrl_byte_valid &&
                      ready_q && !bus.i_u_ins_mem_ctrl_abort;

    u_byte_packer u_packer (
        .i_sys_clock (i_sys_clock),
        .i_sys_reset (i_sys_reset),
        .clear_i     (pk_clear),
        .push_i      (pk_push),
        .byte_i      (bus.i_u_ins_mem_ctrl_byte),
        .full_c      (pk_full),
        .word_c      (pk_word)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        wr_ins_d = '0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.i_u_ins_mem_ctrl_load_start) begin
                    if (cnt_legal) begin
                        count_d = IDX_W'(bus.i_u_ins_mem_ctrl_word_cnt);
                        idx_d   = '0;
                        state_d = S_COLLECT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                if (bus.i_u_ins_mem_ctrl_abort) begin
                    state_d = S_IDLE;
                end else if (pk_full) begin
                    wr_ins_d = pk_word;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                idx_d = idx_q + IDX_W'(1);
                if (bus.i_u_ins_mem_ctrl_abort) begin
                    state_d = S_IDLE;
                end else if (idx_q + IDX_W'(1) == count_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Registered outputs are decoded from the state being entered.
        ready_d = (state_d == S_COLLECT);
        wr_en_d = (state_d == S_WRITE);
        stall_d = (state_d == S_COLLECT) || (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge i_sys_clock or posedge i_sys_reset) begin
        if (i_sys_reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            idx_q    <= '0;
            ready_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            wr_ins_q <= '0;
            stall_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            ready_q  <= ready_d;
            wr_en_q  <= wr_en_d;
            wr_ins_q <= wr_ins_d;
            stall_q  <= stall_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Loader owns the address port only while a session is collecting or writing.
    always_comb begin
        if ((state_q == S_COLLECT) || (state_q == S_WRITE)) begin
            bus.o_u_ins_mem_ctrl_ins_addr = P_BASE_ADDR + (32'(idx_q) << 2);
        end else begin
            bus.o_u_ins_mem_ctrl_ins_addr = bus.i_u_ins_mem_ctrl_pc;
        end
    end

    assign bus.o_u_ins_mem_ctrl_byte_ready = ready_q;
    assign bus.o_u_ins_mem_ctrl_wr_en      = wr_en_q;
    assign bus.o_u_ins_mem_ctrl_wr_ins     = wr_ins_q;
    assign bus.o_u_ins_mem_ctrl_cpu_stall  = stall_q;
    assign bus.o_u_ins_mem_ctrl_busy       = stall_q;
    assign bus.o_u_ins_mem_ctrl_done       = done_q;
    assign bus.o_u_ins_mem_ctrl_err        = err_q;

endmodule

// File: tb/tb_u_ins_mem_ctrl.sv
// Self-checking bench for u_ins_mem_ctrl: randomized loads against a word-list reference model.
module tb_u_ins_mem_ctrl;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic clk;
    logic rst;

    u_ins_mem_ctrl_if bus();

    u_ins_mem_ctrl #(.P_BASE_ADDR(BASE), .P_DEPTH_WORDS(256)) dut (
        .i_sys_clock (clk),
        .i_sys_reset (rst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire        ready  = bus.o_u_ins_mem_ctrl_byte_ready;
    wire [31:0] iaddr  = bus.o_u_ins_mem_ctrl_ins_addr;
    wire [31:0] wr_ins = bus.o_u_ins_mem_ctrl_wr_ins;
    wire        wr_en  = bus.o_u_ins_mem_ctrl_wr_en;
    wire        stall  = bus.o_u_ins_mem_ctrl_cpu_stall;
    wire        busy   = bus.o_u_ins_mem_ctrl_busy;
    wire        done   = bus.o_u_ins_mem_ctrl_done;
    wire        err    = bus.o_u_ins_mem_ctrl_err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ld_bytes[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int cyc_no, first_wr, done_cyc, done_cnt, err_cnt;
    int stall_first, stall_last, addr_viol, ctl_viol;

    function automatic logic [31:0] exp_word(input int k);
        return {ld_bytes[4*k], ld_bytes[4*k+1], ld_bytes[4*k+2], ld_bytes[4*k+3]};
    endfunction

    task automatic clear_obs();
        obs_addr.delete(); obs_data.delete();
        cyc_no = 0; first_wr = -1; done_cyc = -1; done_cnt = 0; err_cnt = 0;
        stall_first = -1; stall_last = -1; addr_viol = 0; ctl_viol = 0;
    endtask

    // Advance one cycle and record what the memory port and status outputs did.
    task automatic step();
        logic [31:0] exp_a;
        @(posedge clk); #1;
        cyc_no++;
        exp_a = BASE + 32'(obs_addr.size()) * 32'd4;
        if (stall === 1'b1) begin
            if (stall_first < 0) stall_first = cyc_no;
            stall_last = cyc_no;
            if (iaddr !== exp_a) addr_viol++;
            if (busy !== 1'b1 || (wr_en !== 1'b1 && ready !== 1'b1)) ctl_viol++;
        end else begin
            if (iaddr !== bus.i_u_ins_mem_ctrl_pc) addr_viol++;
            if (ready !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) ctl_viol++;
        end
        if (wr_en === 1'b1) begin
            obs_addr.push_back(iaddr);
            obs_data.push_back(wr_ins);
            if (first_wr < 0) first_wr = cyc_no;
        end
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc_no; end
        if (err === 1'b1) err_cnt++;
    endtask

    task automatic fill_bytes(input int n);
        ld_bytes.delete();
        for (int i = 0; i < 4 * n; i++) ld_bytes.push_back(8'($urandom));
    endtask

    // Run one load session; abort_byte >= 0 asserts abort when that byte is offered.
    task automatic do_load(input int n, input int gmin, input int gmax, input int abort_byte);
        int idx, gap, budget;
        bit acc, aborted;
        step();
        clear_obs();
        idx = 0; aborted = 0; budget = 25 * n + 40;
        gap = $urandom_range(gmax, gmin);
        bus.i_u_ins_mem_ctrl_pc = $urandom;
        bus.i_u_ins_mem_ctrl_load_start = 1'b1;
        bus.i_u_ins_mem_ctrl_word_cnt = 16'(n);
        step();
        bus.i_u_ins_mem_ctrl_load_start = 1'b0;
        while (done_cnt == 0 && !aborted) begin
            bus.i_u_ins_mem_ctrl_byte_valid = 1'b0;
            bus.i_u_ins_mem_ctrl_abort = 1'b0;
            if (idx < 4 * n) begin
                if (gap > 0) gap--;
                else begin
                    bus.i_u_ins_mem_ctrl_byte_valid = 1'b1;
                    bus.i_u_ins_mem_ctrl_byte = ld_bytes[idx];
                    if (idx == abort_byte && ready === 1'b1) bus.i_u_ins_mem_ctrl_abort = 1'b1;
                end
            end
            acc = bus.i_u_ins_mem_ctrl_byte_valid && (ready === 1'b1) && !bus.i_u_ins_mem_ctrl_abort;
            if (bus.i_u_ins_mem_ctrl_abort) aborted = 1;
            step();
            if (acc) begin idx++; gap = $urandom_range(gmax, gmin); end
            if (cyc_no > budget) begin
                checks++; errors++;
                $display("FAIL load_timeout n=%0d cycles=%0d words_written=%0d", n, cyc_no, obs_addr.size());
                break;
            end
        end
        bus.i_u_ins_mem_ctrl_byte_valid = 1'b0;
        bus.i_u_ins_mem_ctrl_abort = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (stall !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_stall stall=%b busy=%b need 0", stall, busy); end
        checks++; if (ready !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL reset_port ready=%b wr_en=%b need 0", ready, wr_en); end
        checks++; if (wr_ins !== 32'd0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_misc wr_ins=%h done=%b err=%b need 0", wr_ins, done, err); end
        checks++; if (iaddr !== bus.i_u_ins_mem_ctrl_pc) begin errors++; $display("FAIL reset_addr got %h need %h", iaddr, bus.i_u_ins_mem_ctrl_pc); end
    endtask

    task automatic test_single_word();
        ld_bytes = '{8'h20, 8'h09, 8'h7F, 8'hFF};
        do_load(1, 0, 0, -1);
        checks++; if (obs_addr.size() !== 1) begin errors++; $display("FAIL single_nwrites got %0d need 1", obs_addr.size()); end
        checks++; if (obs_addr[0] !== BASE) begin errors++; $display("FAIL single_addr got %h need %h", obs_addr[0], BASE); end
        checks++; if (obs_data[0] !== 32'h2009_7FFF) begin errors++; $display("FAIL single_data got %h need 20097fff", obs_data[0]); end
        checks++; if (first_wr !== 5) begin errors++; $display("FAIL single_wr_cycle got %0d need 5", first_wr); end
        checks++; if (done_cyc !== 6 || done_cnt !== 1) begin errors++; $display("FAIL single_done cycle=%0d count=%0d need 6/1", done_cyc, done_cnt); end
        checks++; if (stall_first !== 1 || stall_last !== 5) begin errors++; $display("FAIL single_stall %0d..%0d need 1..5", stall_first, stall_last); end
        checks++; if (addr_viol !== 0 || ctl_viol !== 0) begin errors++; $display("FAIL single_port addr_viol=%0d ctl_viol=%0d need 0", addr_viol, ctl_viol); end
    endtask

    task automatic test_gaps();
        ld_bytes = '{8'h20, 8'h09, 8'h7F, 8'hFF, 8'h00, 8'h00, 8'h44, 8'h44};
        do_load(2, 2, 2, -1);
        checks++; if (obs_addr.size() !== 2) begin errors++; $display("FAIL gaps_nwrites got %0d need 2", obs_addr.size()); end
        checks++; if (obs_addr[0] !== BASE || obs_addr[1] !== BASE + 32'd4) begin errors++; $display("FAIL gaps_addr got %h %h", obs_addr[0], obs_addr[1]); end
        checks++; if (obs_data[1] !== 32'h0000_4444) begin errors++; $display("FAIL gaps_data got %h need 00004444", obs_data[1]); end
        checks++; if (done_cnt !== 1 || stall_last !== done_cyc - 1) begin errors++; $display("FAIL gaps_done count=%0d stall_last=%0d done=%0d", done_cnt, stall_last, done_cyc); end
        checks++; if (addr_viol !== 0 || ctl_viol !== 0) begin errors++; $display("FAIL gaps_port addr_viol=%0d ctl_viol=%0d need 0", addr_viol, ctl_viol); end
    endtask

    task automatic test_illegal();
        logic [15:0] bad[3];
        bad = '{16'd0, 16'd257, 16'hFFFF};
        bus.i_u_ins_mem_ctrl_pc = 32'h0040_0008;
        step();
        checks++; if (iaddr !== 32'h0040_0008 || wr_en !== 1'b0) begin errors++; $display("FAIL idle_pass addr=%h wr_en=%b need 00400008/0", iaddr, wr_en); end
        for (int i = 0; i < 3; i++) begin
            bus.i_u_ins_mem_ctrl_load_start = 1'b1;
            bus.i_u_ins_mem_ctrl_word_cnt = bad[i];
            step();
            bus.i_u_ins_mem_ctrl_load_start = 1'b0;
            checks++; if (err !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL illegal_err cnt=%0d err=%b stall=%b need 1/0", bad[i], err, stall); end
            step();
            checks++; if (err !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL illegal_pulse cnt=%0d err=%b stall=%b need 0/0", bad[i], err, stall); end
        end
    endtask

    task automatic test_abort();
        fill_bytes(3);
        do_load(3, 0, 1, 6);
        checks++; if (obs_addr.size() !== 1 || obs_data[0] !== exp_word(0)) begin errors++; $display("FAIL abort_mid writes=%0d data=%h need 1/%h", obs_addr.size(), obs_data[0], exp_word(0)); end
        checks++; if (stall !== 1'b0 || iaddr !== bus.i_u_ins_mem_ctrl_pc) begin errors++; $display("FAIL abort_release stall=%b addr=%h pc=%h", stall, iaddr, bus.i_u_ins_mem_ctrl_pc); end
        for (int i = 0; i < 6; i++) step();
        checks++; if (obs_addr.size() !== 1 || done_cnt !== 0) begin errors++; $display("FAIL abort_quiet writes=%0d done=%0d need 1/0", obs_addr.size(), done_cnt); end
        fill_bytes(2);
        do_load(2, 0, 0, 3);
        for (int i = 0; i < 4; i++) step();
        checks++; if (obs_addr.size() !== 0 || done_cnt !== 0) begin errors++; $display("FAIL abort_4th writes=%0d done=%0d need 0/0", obs_addr.size(), done_cnt); end
    endtask

    task automatic test_reset_mid();
        step();
        bus.i_u_ins_mem_ctrl_load_start = 1'b1;
        bus.i_u_ins_mem_ctrl_word_cnt = 16'd2;
        step();
        bus.i_u_ins_mem_ctrl_load_start = 1'b0;
        bus.i_u_ins_mem_ctrl_byte_valid = 1'b1;
        bus.i_u_ins_mem_ctrl_byte = 8'hA5;
        step(); step();
        bus.i_u_ins_mem_ctrl_byte_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || busy !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL rst_async stall=%b busy=%b ready=%b need 0", stall, busy, ready); end
        checks++; if (iaddr !== bus.i_u_ins_mem_ctrl_pc || wr_en !== 1'b0) begin errors++; $display("FAIL rst_async_port addr=%h wr_en=%b pc=%h", iaddr, wr_en, bus.i_u_ins_mem_ctrl_pc); end
        @(posedge clk); #1 rst = 1'b0;
        fill_bytes(1);
        do_load(1, 0, 0, -1);
        checks++; if (obs_addr[0] !== BASE || obs_data[0] !== exp_word(0)) begin errors++; $display("FAIL rst_reload addr=%h data=%h need %h/%h", obs_addr[0], obs_data[0], BASE, exp_word(0)); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int n;
            n = $urandom_range(8, 1);
            fill_bytes(n);
            do_load(n, 0, 3, -1);
            checks++; if (obs_addr.size() !== n || done_cnt !== 1) begin errors++; $display("FAIL rand_count it=%0d writes=%0d done=%0d need %0d/1", it, obs_addr.size(), done_cnt, n); end
            for (int k = 0; k < n && k < obs_addr.size(); k++) begin
                checks++;
                if (obs_addr[k] !== BASE + 32'(4 * k) || obs_data[k] !== exp_word(k)) begin
                    errors++; $display("FAIL rand_word it=%0d k=%0d got %h@%h need %h@%h", it, k, obs_data[k], obs_addr[k], exp_word(k), BASE + 32'(4 * k));
                end
            end
            checks++; if (addr_viol !== 0 || ctl_viol !== 0) begin errors++; $display("FAIL rand_port it=%0d addr_viol=%0d ctl_viol=%0d", it, addr_viol, ctl_viol); end
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        fill_bytes(256);
        do_load(256, 0, 0, -1);
        bad = 0;
        for (int k = 0; k < obs_data.size(); k++) if (obs_data[k] !== exp_word(k)) bad++;
        checks++; if (obs_addr.size() !== 256 || bad !== 0) begin errors++; $display("FAIL full_depth writes=%0d bad_words=%0d need 256/0", obs_addr.size(), bad); end
        checks++; if (obs_addr[255] !== 32'h0040_03FC) begin errors++; $display("FAIL full_last_addr got %h need 004003fc", obs_addr[255]); end
        checks++; if (done_cyc !== 5 * 256 + 1) begin errors++; $display("FAIL full_done_cycle got %0d need %0d", done_cyc, 5 * 256 + 1); end
        fill_bytes(2);
        do_load(2, 0, 0, -1);
        checks++; if (obs_addr[0] !== BASE || obs_data[1] !== exp_word(1) || done_cyc !== 11) begin errors++; $display("FAIL b2b_second addr=%h data=%h done=%0d", obs_addr[0], obs_data[1], done_cyc); end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_u_ins_mem_ctrl_load_start = 1'b0;
        bus.i_u_ins_mem_ctrl_word_cnt = 16'd0;
        bus.i_u_ins_mem_ctrl_abort = 1'b0;
        bus.i_u_ins_mem_ctrl_byte = 8'd0;
        bus.i_u_ins_mem_ctrl_byte_valid = 1'b0;
        bus.i_u_ins_mem_ctrl_pc = 32'h1234_5678;
        clear_obs();
        #3;
        test_reset();
        @(posedge clk); #1 rst = 1'b0;
        test_single_word();
        test_gaps();
        test_illegal();
        test_abort();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
